snoop_bus_agent: RTL and testbench
==================================

// Module: snoop_bus_agent
// PURPOSE
//  Per-core bus agent on the cache side of the two-core MSI snooping bus. It is the agent the
//  bus arbiter/router talks to: one instance per core, between the L1 cache controller and the bus.
//  Requester half: turns an L1 miss/upgrade into a held bus request, waits for grant, then returns
//  peer/L2 data to L1. Responder half: snoops the peer's forwarded op, supplies hit/data,
//  downgrades/invalidates the local line and pulses a flush (M-line writeback) to L2.
// PARAMETERS
//  ADDR_W 32  address width
//  DATA_W 32  word width
//  TAG_W  24  tag width; tag = addr[ADDR_W-1 -: TAG_W]
//  CNT_W  16  width of saturating snoop-hit counter
// PORTS
//  clk             in  1       clock, all state on rising edge
//  reset           in  1       asynchronous, active-low reset
//  cpu_req_valid   in  1       L1 requests bus transaction (level, held until cpu_req_ready)
//  cpu_req_op      in  2       00 BusRd, 01 BusUpgr, 10 BusRdX (11 illegal, ignored)
//  cpu_req_addr    in  ADDR_W  request address
//  cpu_req_ready   out 1       1-cycle pulse: request accepted (latched)
//  cpu_rsp_valid   out 1       1-cycle pulse: transaction done
//  cpu_rsp_data    out DATA_W  returned word (valid with cpu_rsp_valid)
//  cpu_rsp_peer    out 1       1 = data supplied by peer cache, 0 = L2
//  req_core        out 1       bus request to arbiter
//  stall_core      out 1       agent still needs the bus
//  grant_core      in  1       grant from arbiter
//  bus_op_to_bus   out 2       own op; 2'b11 (BusNoN) when not requesting
//  bus_addr_to_bus out ADDR_W  own request address
//  bus_data_from   in  DATA_W  response word routed back by arbiter
//  hit_from_bus    in  1       1 = response came from peer cache
//  snoop_op        in  2       peer's forwarded op (11 = none)
//  snoop_addr      in  ADDR_W  peer's forwarded address
//  snoop_lookup_addr out ADDR_W address to L1 tag/data lookup (= snoop_addr, comb.)
//  snoop_line_state in 2      L1 state for lookup: 00 I, 01 S, 10 M
//  snoop_line_data in  DATA_W  L1 data for lookup
//  snoop_hit_out   out 1       to arbiter: local copy supplies data (comb.)
//  snoop_data_out  out DATA_W  to arbiter: local data (0 when no hit)
//  state_wr_en     out 1       1-cycle pulse: update L1 line state
//  state_wr_addr   out ADDR_W  line to update
//  state_wr_val    out 2       new state (01 S or 00 I)
//  flush_req       out 1       1-cycle pulse: write back M line to L2
//  flush_data      out DATA_W  writeback data;  flush_tag out TAG_W writeback tag
//  snoop_hit_cnt   out CNT_W   saturating count of snoop hits
// BEHAVIOUR
//  Reset (reset=0, async): FSM->IDLE; all outputs 0 except bus_op_to_bus=2'b11; counter 0.
//  Requester FSM IDLE->REQ->RESP->IDLE:
//   IDLE: cpu_req_valid && op!=11 -> latch op/addr, pulse cpu_req_ready, go REQ (1 cycle).
//   REQ: req_core=1, bus_op_to_bus=latched op, bus_addr_to_bus=latched addr;
//        stall_core = !grant_core (comb.). On edge with grant_core=1: capture bus_data_from,
//        hit_from_bus -> RESP. No grant: stay, hold all outputs stable, no timeout.
//   RESP: req_core=0, op=11, pulse cpu_rsp_valid with captured data/peer flag -> IDLE.
//   BusUpgr response data is don't-care to L1 but still reported.
//  Responder (combinational response, registered side effects):
//   hit = snoop_op!=11 && snoop_line_state!=00 && snoop_op!=01.
//   snoop_hit_out=hit, snoop_data_out=hit?snoop_line_data:0 in same cycle.
//   Next cycle, one pulse:
//    BusRd on M: state_wr_val=S, flush_req=1, flush_data=line data, flush_tag=addr tag.
//    BusRd on S/I: no action.  BusRdX on M: I + flush.  BusRdX/BusUpgr on S: I, no flush.
//   snoop_hit_cnt += 1 per hit cycle, saturates at all-ones.
//  Collision: in REQ with latched op BusUpgr and snoop BusRdX/BusUpgr to same line (tag match)
//   -> latched op becomes BusRdX (own copy invalidated) before next bus cycle.
//  Own request and snoop handled in parallel; snoop side effects never wait on requester FSM.
//  Reset mid-transaction: drop request immediately, no cpu_rsp_valid, no pending pulses.
// TESTING
//  BusRd 0x100 uncontended, grant=1, L2 data 0xCAFE -> ready, rsp next+1, data 0xCAFE, peer=0.
//  Grant low 5 cycles -> req/op/addr stable, stall_core=1, rsp 1 cycle after grant.
//  Snoop BusRd 0x200, local M data 0x55 -> same-cycle hit=1, data 0x55; next: wr S, flush tag 0x000002.
//  Pending BusUpgr 0x300 + snoop BusRdX 0x300 -> bus op becomes 10, line invalidated, no flush.
//  Reset low during REQ -> op=11, req=0 at once; no rsp pulse; snoop_hit_cnt=0.
//  2^CNT_W+3 snoop hits -> counter holds all-ones.

Source files
------------

// File: rtl/snoop_bus_agent.sv
// Per-core MSI snooping bus agent: a requester FSM that carries an L1 miss/upgrade
// across the bus, and a responder that answers peer snoops and downgrades/flushes the local line.
module snoop_bus_agent #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 24,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  // L1 request / response side
  input  logic              cpu_req_valid,
  input  logic [1:0]        cpu_req_op,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  output logic              cpu_req_ready,
  output logic              cpu_rsp_valid,
  output logic [DATA_W-1:0] cpu_rsp_data,
  output logic              cpu_rsp_peer,
  // arbiter side, own request
  output logic              req_core,
  output logic              stall_core,
  input  logic              grant_core,
  output logic [1:0]        bus_op_to_bus,
  output logic [ADDR_W-1:0] bus_addr_to_bus,
  input  logic [DATA_W-1:0] bus_data_from,
  input  logic              hit_from_bus,
  // arbiter side, peer snoop
  input  logic [1:0]        snoop_op,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic [ADDR_W-1:0] snoop_lookup_addr,
  input  logic [1:0]        snoop_line_state,
  input  logic [DATA_W-1:0] snoop_line_data,
  output logic              snoop_hit_out,
  output logic [DATA_W-1:0] snoop_data_out,
  // L1 state update and L2 writeback
  output logic              state_wr_en,
  output logic [ADDR_W-1:0] state_wr_addr,
  output logic [1:0]        state_wr_val,
  output logic              flush_req,
  output logic [DATA_W-1:0] flush_data,
  output logic [TAG_W-1:0]  flush_tag,
  output logic [CNT_W-1:0]  snoop_hit_cnt,
  // requester FSM state for observation
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_UPGR = 2'b01;
  localparam logic [1:0] OP_RDX  = 2'b10;
  localparam logic [1:0] OP_NONE = 2'b11;

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_M = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10
  } req_state_t;

  req_state_t state;

  logic       collide;
  logic       snoop_hit;
  logic       fx_wr;
  logic       fx_flush;
  logic [1:0] fx_val;

  assign dbg_state = state;

  // Handshake: L1 holds cpu_req_valid (with op/addr) as a level until the agent returns a
  // one-cycle cpu_req_ready; the request is latched on that edge. cpu_rsp_valid is a one-cycle
  // pulse with no back-pressure. On the bus side req_core stays high until the edge on which
  // grant_core is sampled high; that edge also captures bus_data_from/hit_from_bus.
  assign stall_core = (state == REQ) && !grant_core;

  // A peer upgrade/exclusive read of the line we hold in S kills our copy, so a pending upgrade
  // must turn into a full read-exclusive before it reaches the bus.
  assign collide = (state == REQ) && (bus_op_to_bus == OP_UPGR) &&
                   ((snoop_op == OP_RDX) || (snoop_op == OP_UPGR)) &&
                   (snoop_addr[ADDR_W-1 -: TAG_W] == bus_addr_to_bus[ADDR_W-1 -: TAG_W]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      cpu_req_ready   <= 1'b0;
      cpu_rsp_valid   <= 1'b0;
      cpu_rsp_data    <= '0;
      cpu_rsp_peer    <= 1'b0;
      req_core        <= 1'b0;
      bus_op_to_bus   <= OP_NONE;
      bus_addr_to_bus <= '0;
    end else begin
      cpu_req_ready <= 1'b0;
      cpu_rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req_valid && (cpu_req_op != OP_NONE)) begin
            cpu_req_ready   <= 1'b1;
            req_core        <= 1'b1;
            bus_op_to_bus   <= cpu_req_op;
            bus_addr_to_bus <= cpu_req_addr;
            state           <= REQ;
          end
        end
        REQ: begin
          if (grant_core) begin
            cpu_rsp_data    <= bus_data_from;
            cpu_rsp_peer    <= hit_from_bus;
            cpu_rsp_valid   <= 1'b1;
            req_core        <= 1'b0;
            bus_op_to_bus   <= OP_NONE;
            bus_addr_to_bus <= '0;
            state           <= RESP;
          end else if (collide) begin
            bus_op_to_bus <= OP_RDX;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Responder: the hit/data answer is combinational so the arbiter sees it in the snoop cycle.
  assign snoop_lookup_addr = snoop_addr;
  assign snoop_hit      = (snoop_op != OP_NONE) && (snoop_line_state != ST_I) &&
                          (snoop_op != OP_UPGR);
  assign snoop_hit_out  = snoop_hit;
  assign snoop_data_out = snoop_hit ? snoop_line_data : '0;

  always_comb begin
    fx_wr    = 1'b0;
    fx_flush = 1'b0;
    fx_val   = ST_I;
    if ((snoop_line_state == ST_M) && (snoop_op == OP_RD)) begin
      fx_wr    = 1'b1;
      fx_flush = 1'b1;
      fx_val   = ST_S;
    end else if ((snoop_line_state == ST_M) && (snoop_op == OP_RDX)) begin
      fx_wr    = 1'b1;
      fx_flush = 1'b1;
      fx_val   = ST_I;
    end else if ((snoop_line_state == ST_S) &&
                 ((snoop_op == OP_RDX) || (snoop_op == OP_UPGR))) begin
      fx_wr    = 1'b1;
      fx_val   = ST_I;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_wr_en   <= 1'b0;
      state_wr_addr <= '0;
      state_wr_val  <= ST_I;
      flush_req     <= 1'b0;
      flush_data    <= '0;
      flush_tag     <= '0;
      snoop_hit_cnt <= '0;
    end else begin
      state_wr_en <= fx_wr;
      flush_req   <= fx_flush;
      if (fx_wr) begin
        state_wr_addr <= snoop_addr;
        state_wr_val  <= fx_val;
      end
      if (fx_flush) begin
        flush_data <= snoop_line_data;
        flush_tag  <= snoop_addr[ADDR_W-1 -: TAG_W];
      end
      if (snoop_hit && (snoop_hit_cnt != {CNT_W{1'b1}})) begin
        snoop_hit_cnt <= snoop_hit_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_snoop_bus_agent.sv
// Bench for snoop_bus_agent: directed bus/snoop scenarios plus a randomized phase where own
// requests and peer snoops run concurrently, checked by a scoreboard monitor.
module tb_snoop_bus_agent;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TW = 24;
  localparam int CW = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef struct packed {
    logic [1:0]    op;
    logic [AW-1:0] addr;
  } bus_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          peer;
  } rsp_t;

  typedef struct packed {
    logic [31:0]   due;
    logic [AW-1:0] addr;
    logic [1:0]    val;
    logic          flush;
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } fx_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req_valid;
  logic [1:0]    cpu_req_op;
  logic [AW-1:0] cpu_req_addr;
  logic          cpu_req_ready;
  logic          cpu_rsp_valid;
  logic [DW-1:0] cpu_rsp_data;
  logic          cpu_rsp_peer;
  logic          req_core;
  logic          stall_core;
  logic          grant_core;
  logic [1:0]    bus_op_to_bus;
  logic [AW-1:0] bus_addr_to_bus;
  logic [DW-1:0] bus_data_from;
  logic          hit_from_bus;
  logic [1:0]    snoop_op;
  logic [AW-1:0] snoop_addr;
  logic [AW-1:0] snoop_lookup_addr;
  logic [1:0]    snoop_line_state;
  logic [DW-1:0] snoop_line_data;
  logic          snoop_hit_out;
  logic [DW-1:0] snoop_data_out;
  logic          state_wr_en;
  logic [AW-1:0] state_wr_addr;
  logic [1:0]    state_wr_val;
  logic          flush_req;
  logic [DW-1:0] flush_data;
  logic [TW-1:0] flush_tag;
  logic [CW-1:0] snoop_hit_cnt;
  logic [1:0]    dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] cyc = '0;

  bus_t exp_bus_q[$];
  rsp_t exp_rsp_q[$];
  fx_t  exp_fx_q[$];
  logic          exp_hit_now;
  logic [DW-1:0] exp_sdata_now;
  logic [AW-1:0] exp_lookup_now;
  int            model_cnt = 0;
  rsp_t          mon_r;
  fx_t           mon_f;

  snoop_bus_agent #(.ADDR_W(AW), .DATA_W(DW), .TAG_W(TW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_op(cpu_req_op), .cpu_req_addr(cpu_req_addr),
    .cpu_req_ready(cpu_req_ready), .cpu_rsp_valid(cpu_rsp_valid),
    .cpu_rsp_data(cpu_rsp_data), .cpu_rsp_peer(cpu_rsp_peer),
    .req_core(req_core), .stall_core(stall_core), .grant_core(grant_core),
    .bus_op_to_bus(bus_op_to_bus), .bus_addr_to_bus(bus_addr_to_bus),
    .bus_data_from(bus_data_from), .hit_from_bus(hit_from_bus),
    .snoop_op(snoop_op), .snoop_addr(snoop_addr), .snoop_lookup_addr(snoop_lookup_addr),
    .snoop_line_state(snoop_line_state), .snoop_line_data(snoop_line_data),
    .snoop_hit_out(snoop_hit_out), .snoop_data_out(snoop_data_out),
    .state_wr_en(state_wr_en), .state_wr_addr(state_wr_addr), .state_wr_val(state_wr_val),
    .flush_req(flush_req), .flush_data(flush_data), .flush_tag(flush_tag),
    .snoop_hit_cnt(snoop_hit_cnt), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic miss(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got unexpected/missing event, expected none/one (t=%0t)", name, $time);
  endtask

  // Drive one snoop and record what MSI says must happen: a hit answers with data now; an
  // M line read by the peer is written back; any peer write intent invalidates our copy.
  task automatic snoop_set(input logic [1:0] op, input logic [AW-1:0] addr,
                           input logic [1:0] st, input logic [DW-1:0] data);
    fx_t f;
    snoop_op = op; snoop_addr = addr; snoop_line_state = st; snoop_line_data = data;
    exp_lookup_now = addr;
    exp_hit_now    = ((op == 2'b00) || (op == 2'b10)) && (st != 2'b00);
    exp_sdata_now  = exp_hit_now ? data : '0;
    if (exp_hit_now && model_cnt < CNT_MAX) model_cnt++;
    f.due = cyc + 1; f.addr = addr; f.data = data; f.tag = addr[AW-1 -: TW];
    f.flush = 1'b0; f.val = 2'b00;
    if (st == 2'b10 && op == 2'b00) begin
      f.val = 2'b01; f.flush = 1'b1; exp_fx_q.push_back(f);
    end else if (st == 2'b10 && op == 2'b10) begin
      f.flush = 1'b1; exp_fx_q.push_back(f);
    end else if (st == 2'b01 && (op == 2'b10 || op == 2'b01)) begin
      exp_fx_q.push_back(f);
    end
  endtask

  task automatic snoop_cycle(input logic [1:0] op, input logic [AW-1:0] addr,
                             input logic [1:0] st, input logic [DW-1:0] data);
    @(posedge clk); #1;
    snoop_set(op, addr, st, data);
  endtask

  task automatic issue(input logic [1:0] op, input logic [AW-1:0] addr, output bit ok);
    bus_t b;
    int n;
    b.op = op; b.addr = addr;
    exp_bus_q.push_back(b);
    @(posedge clk); #1;
    cpu_req_valid = 1'b1; cpu_req_op = op; cpu_req_addr = addr;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!cpu_req_ready && n < 16);
    cpu_req_valid = 1'b0; cpu_req_addr = $urandom;
    chk("req_ready", cpu_req_ready, 1'b1);
    chk("req_accept_latency", n, 1);
    ok = cpu_req_ready;
    if (!ok) exp_bus_q.delete();
  endtask

  task automatic do_request(input logic [1:0] op, input logic [AW-1:0] addr, input int waits,
                            input logic [DW-1:0] data, input logic peer, input bit collide);
    bit ok;
    rsp_t r;
    issue(op, addr, ok);
    if (!ok) return;
    for (int i = 0; i < waits; i++) begin
      grant_core = 1'b0; bus_data_from = $urandom; hit_from_bus = 1'($urandom);
      if (collide && i == 0) snoop_set(2'b10, addr, 2'b01, $urandom);
      @(posedge clk); #1;
      if (collide && i == 0) begin
        snoop_set(2'b11, '0, 2'b00, '0);
        if (exp_bus_q.size() > 0) exp_bus_q[0].op = 2'b10;
      end
    end
    grant_core = 1'b1; bus_data_from = data; hit_from_bus = peer;
    r.data = data; r.peer = peer;
    exp_rsp_q.push_back(r);
    @(posedge clk); #1;
    grant_core = 1'b0; bus_data_from = $urandom;
    chk("rsp_latency", cpu_rsp_valid, 1'b1);
  endtask

  task automatic rand_requests(input int n);
    logic [1:0] op;
    for (int t = 0; t < n; t++) begin
      op = 2'($urandom_range(0, 2));
      do_request(op, {1'b0, 31'($urandom)}, $urandom_range(0, 4), $urandom, 1'($urandom), 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  task automatic rand_snoops(input int n);
    for (int t = 0; t < n; t++)
      snoop_cycle(2'($urandom), {1'b1, 31'($urandom)}, 2'($urandom_range(0, 2)), $urandom);
    snoop_cycle(2'b11, '0, 2'b00, '0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset) begin
      chk("snoop_hit_out", snoop_hit_out, exp_hit_now);
      chk("snoop_data_out", snoop_data_out, exp_sdata_now);
      chk("snoop_lookup_addr", snoop_lookup_addr, exp_lookup_now);
      if (req_core) begin
        if (exp_bus_q.size() == 0) miss("req_unexpected");
        else begin
          chk("bus_op", bus_op_to_bus, exp_bus_q[0].op);
          chk("bus_addr", bus_addr_to_bus, exp_bus_q[0].addr);
          chk("stall_req", stall_core, !grant_core);
          if (grant_core) void'(exp_bus_q.pop_front());
        end
      end else begin
        chk("bus_op_idle", bus_op_to_bus, 2'b11);
        chk("stall_idle", stall_core, 1'b0);
      end
      if (cpu_rsp_valid) begin
        if (exp_rsp_q.size() == 0) miss("rsp_unexpected");
        else begin
          mon_r = exp_rsp_q.pop_front();
          chk("rsp_data", cpu_rsp_data, mon_r.data);
          chk("rsp_peer", cpu_rsp_peer, mon_r.peer);
        end
      end
      while (exp_fx_q.size() > 0 && exp_fx_q[0].due < cyc) begin
        void'(exp_fx_q.pop_front());
        miss("state_wr_missing");
      end
      if (exp_fx_q.size() > 0 && exp_fx_q[0].due == cyc) begin
        mon_f = exp_fx_q.pop_front();
        chk("state_wr_en", state_wr_en, 1'b1);
        chk("state_wr_addr", state_wr_addr, mon_f.addr);
        chk("state_wr_val", state_wr_val, mon_f.val);
        chk("flush_req", flush_req, mon_f.flush);
        if (mon_f.flush) begin
          chk("flush_data", flush_data, mon_f.data);
          chk("flush_tag", flush_tag, mon_f.tag);
        end
      end else begin
        if (state_wr_en) miss("state_wr_unexpected");
        if (flush_req) miss("flush_unexpected");
      end
    end
  end

  initial begin
    bit ok;
    cpu_req_valid = 1'b0; cpu_req_op = 2'b00; cpu_req_addr = '0;
    grant_core = 1'b0; bus_data_from = '0; hit_from_bus = 1'b0;
    snoop_set(2'b11, '0, 2'b00, '0);
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    chk("reset_req_core", req_core, 1'b0);
    chk("reset_stall", stall_core, 1'b0);
    chk("reset_req_ready", cpu_req_ready, 1'b0);
    chk("reset_rsp_valid", cpu_rsp_valid, 1'b0);
    chk("reset_bus_op", bus_op_to_bus, 2'b11);
    chk("reset_bus_addr", bus_addr_to_bus, '0);
    chk("reset_state_wr", state_wr_en, 1'b0);
    chk("reset_flush", flush_req, 1'b0);
    chk("reset_cnt", snoop_hit_cnt, '0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // uncontended BusRd from L2, then a 5-cycle grant stall served by the peer
    do_request(2'b00, 32'h0000_0100, 0, 32'h0000_CAFE, 1'b0, 1'b0);
    do_request(2'b00, 32'h0000_0140, 5, 32'h1234_5678, 1'b1, 1'b0);

    // snoop matrix: M/BusRd, S/BusRd, S/BusUpgr, M/BusRdX, I/BusRdX
    snoop_cycle(2'b00, 32'h0000_0200, 2'b10, 32'h0000_0055);
    snoop_cycle(2'b00, 32'h0000_0240, 2'b01, 32'h0000_0077);
    snoop_cycle(2'b01, 32'h0000_0280, 2'b01, 32'h0000_0088);
    snoop_cycle(2'b10, 32'h0000_02C0, 2'b10, 32'h0000_0099);
    snoop_cycle(2'b10, 32'h0000_0300, 2'b00, 32'h0000_00AA);
    snoop_cycle(2'b11, '0, 2'b00, '0);
    chk("hit_cnt_directed", snoop_hit_cnt, model_cnt);

    // pending BusUpgr hit by a peer BusRdX on the same line
    do_request(2'b01, 32'h0000_0300, 2, 32'h0000_BEEF, 1'b1, 1'b1);

    // illegal op is never accepted
    @(posedge clk); #1;
    cpu_req_valid = 1'b1; cpu_req_op = 2'b11; cpu_req_addr = 32'h0000_0700;
    repeat (3) begin
      @(posedge clk); #1;
      chk("illegal_op_ready", cpu_req_ready, 1'b0);
      chk("illegal_op_req", req_core, 1'b0);
    end
    cpu_req_valid = 1'b0;

    // concurrent own traffic and peer snoops
    fork
      rand_requests(30);
      rand_snoops(200);
    join
    @(posedge clk); #1;
    chk("hit_cnt_random", snoop_hit_cnt, model_cnt);

    // reset while requesting, with a flush-causing snoop in flight
    issue(2'b10, 32'h0000_0400, ok);
    grant_core = 1'b0;
    snoop_set(2'b00, 32'h8000_0500, 2'b10, 32'h0000_0066);
    #2 reset = 1'b0;
    #1;
    chk("midreset_req_core", req_core, 1'b0);
    chk("midreset_bus_op", bus_op_to_bus, 2'b11);
    chk("midreset_stall", stall_core, 1'b0);
    chk("midreset_cnt", snoop_hit_cnt, '0);
    exp_bus_q.delete(); exp_rsp_q.delete(); exp_fx_q.delete();
    model_cnt = 0;
    snoop_set(2'b11, '0, 2'b00, '0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("midreset_no_rsp", cpu_rsp_valid, 1'b0);
      chk("midreset_no_wr", state_wr_en, 1'b0);
      chk("midreset_no_flush", flush_req, 1'b0);
    end

    // counter saturation: fill to all-ones, then 4 more hits
    for (int i = 0; i < CNT_MAX; i++) snoop_cycle(2'b00, 32'h8000_0600, 2'b01, i);
    snoop_cycle(2'b11, '0, 2'b00, '0);
    chk("hit_cnt_full", snoop_hit_cnt, model_cnt);
    for (int i = 0; i < 4; i++) snoop_cycle(2'b00, 32'h8000_0600, 2'b01, i);
    snoop_cycle(2'b11, '0, 2'b00, '0);
    chk("hit_cnt_saturated", snoop_hit_cnt, model_cnt);

    repeat (3) @(posedge clk); #1;
    chk("bus_q_drained", exp_bus_q.size(), 0);
    chk("rsp_q_drained", exp_rsp_q.size(), 0);
    chk("fx_q_drained", exp_fx_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
